// File: rtl/regfile_stage.sv
// Register-read stage: 31x32 integer register file with a busy scoreboard,
// writeback port and a one-entry output register toward execute.
// Optional build macro RF_BYPASS_EN: forwards same-cycle writeback data to the
// operand read and lets that writeback clear a RAW stall in the same cycle.
// Reset is asynchronous, active-low, on port rst.

package regfile_stage_pkg;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = 5;

    // Operand source selection; rf=1 means the operand is read from the register file
    typedef struct packed {
        logic rf;
        logic imm;
    } fwd_sel_t;

    typedef struct packed {
        logic [7:0]       op;
        fwd_sel_t         fwd_rs1;
        fwd_sel_t         fwd_rs2;
        logic [IDX_W-1:0] rd;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } idrf_tdata_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        idrf_tdata_t     idrf;
    } rfex_tdata_t;

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_tdata_t;
endpackage

module regfile_stage
    import regfile_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // decoded instruction from decoder
    input  logic        idrf_tvalid,
    output logic        idrf_tready_c,
    input  idrf_tdata_t idrf_tdata,
    // operands and decoded fields to execute
    output logic        rfex_tvalid,
    input  logic        rfex_tready,
    output rfex_tdata_t rfex_tdata,
    // writeback from execute, never back-pressured
    input  logic        wb_tvalid,
    output logic        wb_tready_c,
    input  wb_tdata_t   wb_tdata,
    // pipeline flush from branch resolution
    input  logic        invalidate
);

    logic [XLEN-1:0]     regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] busy_rd;
    logic                wb_hit;
    logic                hazard;
    logic                accept;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;

    assign wb_tready_c = 1'b1;
    assign wb_hit      = wb_tvalid && (wb_tdata.rd != '0);

    // One-hot busy clear from this cycle's writeback
    always_comb begin
        wb_clr = '0;
        if (wb_hit) wb_clr[wb_tdata.rd] = 1'b1;
    end

    // Busy view used for source-operand checks; WAW always uses the registered bits
    always_comb begin
`ifdef RF_BYPASS_EN
        busy_rd = busy_q & ~wb_clr;
`else
        busy_rd = busy_q;
`endif
    end

    // RAW / WAW hazard detection and input handshake
    always_comb begin
        hazard = (idrf_tdata.fwd_rs1.rf && busy_rd[idrf_tdata.rs1]) ||
                 (idrf_tdata.fwd_rs2.rf && busy_rd[idrf_tdata.rs2]) ||
                 ((idrf_tdata.rd != '0) && busy_q[idrf_tdata.rd]);
        idrf_tready_c = (!rfex_tvalid || rfex_tready) && !hazard && !invalidate;
        accept        = idrf_tvalid && idrf_tready_c;
    end

    // Operand read with x0 hardwired to zero and optional writeback forwarding
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (idrf_tdata.rs1 != '0) rs1_data = regs[idrf_tdata.rs1];
        if (idrf_tdata.rs2 != '0) rs2_data = regs[idrf_tdata.rs2];
`ifdef RF_BYPASS_EN
        if (wb_hit && (wb_tdata.rd == idrf_tdata.rs1)) rs1_data = wb_tdata.data;
        if (wb_hit && (wb_tdata.rd == idrf_tdata.rs2)) rs2_data = wb_tdata.data;
`endif
    end

    // Scoreboard next state: clear on writeback, set on accept (set wins), flush clears all
    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (accept && (idrf_tdata.rd != '0)) busy_d[idrf_tdata.rd] = 1'b1;
        if (invalidate) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // Register array write port; x0 has no storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) regs[IDX_W'(i)] <= '0;
        end else if (wb_hit) begin
            regs[wb_tdata.rd] <= wb_tdata.data;
        end
    end

    // One-entry output register toward execute; contents hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rfex_tvalid <= 1'b0;
            rfex_tdata  <= '0;
        end else if (invalidate) begin
            rfex_tvalid <= 1'b0;
        end else if (accept) begin
            rfex_tvalid         <= 1'b1;
            rfex_tdata.rs1_data <= rs1_data;
            rfex_tdata.rs2_data <= rs2_data;
            rfex_tdata.idrf     <= idrf_tdata;
        end else if (rfex_tready) begin
            rfex_tvalid <= 1'b0;
        end
    end

    // The WAW stall must prevent a same-cycle set and clear of one destination
    a_no_set_clr_same_rd: assert property (@(posedge clk) disable iff (!rst)
        !(accept && (idrf_tdata.rd != '0) && wb_hit && (wb_tdata.rd == idrf_tdata.rd)));

endmodule

// File: tb/tb_regfile_stage.sv
// Directed testbench for regfile_stage; expected timing follows RF_BYPASS_EN.
module tb_regfile_stage;
    import regfile_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        idrf_tvalid;
    logic        idrf_tready_c;
    idrf_tdata_t idrf_tdata;
    logic        rfex_tvalid;
    logic        rfex_tready;
    rfex_tdata_t rfex_tdata;
    logic        wb_tvalid;
    logic        wb_tready_c;
    wb_tdata_t   wb_tdata;
    logic        invalidate;

    int checks;
    int failures;

    idrf_tdata_t ins_a, ins_b, ins_c, ins_d, ins_e, ins_f, ins_g;
    idrf_tdata_t ins_h, ins_i, ins_j, ins_k, ins_l, ins_m, ins_n, ins_p;

    regfile_stage dut (
        .clk           (clk),
        .rst           (rst),
        .idrf_tvalid   (idrf_tvalid),
        .idrf_tready_c (idrf_tready_c),
        .idrf_tdata    (idrf_tdata),
        .rfex_tvalid   (rfex_tvalid),
        .rfex_tready   (rfex_tready),
        .rfex_tdata    (rfex_tdata),
        .wb_tvalid     (wb_tvalid),
        .wb_tready_c   (wb_tready_c),
        .wb_tdata      (wb_tdata),
        .invalidate    (invalidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic idrf_tdata_t mk(input logic [7:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic u1, input logic u2);
        idrf_tdata_t t;
        t.op          = op;
        t.fwd_rs1.rf  = u1;
        t.fwd_rs1.imm = ~u1;
        t.fwd_rs2.rf  = u2;
        t.fwd_rs2.imm = ~u2;
        t.rd          = rd;
        t.rs1         = rs1;
        t.rs2         = rs2;
        t.imm         = {24'h0, op};
        return t;
    endfunction

    function automatic rfex_tdata_t exp_out(input logic [31:0] d1, input logic [31:0] d2,
                                            input idrf_tdata_t t);
        rfex_tdata_t r;
        r.rs1_data = d1;
        r.rs2_data = d2;
        r.idrf     = t;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_tvalid     = 1'b1;
        wb_tdata.rd   = rd;
        wb_tdata.data = data;
    endtask

    task automatic issue(input idrf_tdata_t t);
        idrf_tvalid = 1'b1;
        idrf_tdata  = t;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        idrf_tvalid = 1'b0;
        idrf_tdata  = '0;
        rfex_tready = 1'b1;
        wb_tvalid   = 1'b0;
        wb_tdata    = '0;
        invalidate  = 1'b0;

        ins_a = mk(8'h11, 5'd1,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_b = mk(8'h12, 5'd2,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_c = mk(8'h13, 5'd3,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_d = mk(8'h14, 5'd10, 5'd3, 5'd0, 1'b1, 1'b0);
        ins_e = mk(8'h15, 5'd4,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_f = mk(8'h16, 5'd4,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_g = mk(8'h17, 5'd0,  5'd4, 5'd0, 1'b1, 1'b0);
        ins_h = mk(8'h18, 5'd0,  5'd4, 5'd4, 1'b1, 1'b1);
        ins_i = mk(8'h19, 5'd0,  5'd3, 5'd0, 1'b1, 1'b0);
        ins_j = mk(8'h1a, 5'd0,  5'd0, 5'd0, 1'b1, 1'b1);
        ins_k = mk(8'h1b, 5'd7,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_l = mk(8'h1c, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0);
        ins_m = mk(8'h1d, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0);
        ins_n = mk(8'h1e, 5'd5,  5'd0, 5'd0, 1'b1, 1'b0);
        ins_p = mk(8'h1f, 5'd0,  5'd5, 5'd0, 1'b1, 1'b0);

        // Power-on reset
        #3 rst = 1'b0;
        #4;
        chk("reset_tvalid", 128'(rfex_tvalid), 128'(1'b0));
        chk("reset_tdata", 128'(rfex_tdata), 128'h0);
        chk("wb_tready", 128'(wb_tready_c), 128'(1'b1));
        #15 rst = 1'b1;
        tick();

        // Independent stream: one output per cycle, latency 1
        issue(ins_a);
        settle();
        chk("indep_ready_a", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("indep_valid_a", 128'(rfex_tvalid), 128'(1'b1));
        chk("indep_data_a", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_a)));
        issue(ins_b);
        settle();
        chk("indep_ready_b", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("indep_data_b", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_b)));
        idrf_tvalid = 1'b0;
        tick();
        chk("indep_drain", 128'(rfex_tvalid), 128'(1'b0));

        // RAW on x3
        issue(ins_c);
        tick();
        chk("raw_data_c", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_c)));
        issue(ins_d);
        settle();
        chk("raw_stall", 128'(idrf_tready_c), 128'(1'b0));
        tick();
        chk("raw_stall_novalid", 128'(rfex_tvalid), 128'(1'b0));
        wb(5'd3, 32'hDEADBEEF);
        settle();
`ifdef RF_BYPASS_EN
        chk("raw_wb_cycle_ready", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        wb_tvalid = 1'b0;
`else
        chk("raw_wb_cycle_ready", 128'(idrf_tready_c), 128'(1'b0));
        tick();
        wb_tvalid = 1'b0;
        chk("raw_wb_cycle_novalid", 128'(rfex_tvalid), 128'(1'b0));
        settle();
        chk("raw_after_wb_ready", 128'(idrf_tready_c), 128'(1'b1));
        tick();
`endif
        chk("raw_valid_d", 128'(rfex_tvalid), 128'(1'b1));
        chk("raw_data_d", 128'(rfex_tdata), 128'(exp_out(32'hDEADBEEF, 32'h0, ins_d)));
        idrf_tvalid = 1'b0;
        tick();

        // WAW on x4
        issue(ins_e);
        tick();
        issue(ins_f);
        settle();
        chk("waw_stall", 128'(idrf_tready_c), 128'(1'b0));
        tick();
        chk("waw_stall_novalid", 128'(rfex_tvalid), 128'(1'b0));
        wb(5'd4, 32'h0000_0044);
        settle();
        chk("waw_wb_cycle_stall", 128'(idrf_tready_c), 128'(1'b0));
        tick();
        wb_tvalid = 1'b0;
        settle();
        chk("waw_ready_after_wb", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("waw_data_f", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_f)));
        issue(ins_g);
        settle();
        chk("waw_busy4_kept", 128'(idrf_tready_c), 128'(1'b0));
        idrf_tvalid = 1'b0;
        wb(5'd4, 32'h0000_0055);
        tick();
        wb_tvalid = 1'b0;
        tick();

        // Backpressure: output held three cycles, later writeback not reflected
        issue(ins_h);
        tick();
        chk("bp_data_h", 128'(rfex_tdata), 128'(exp_out(32'h55, 32'h55, ins_h)));
        rfex_tready = 1'b0;
        issue(ins_i);
        wb(5'd4, 32'h0000_0066);
        settle();
        chk("bp_ready_low", 128'(idrf_tready_c), 128'(1'b0));
        for (int c = 0; c < 3; c++) begin
            tick();
            wb_tvalid = 1'b0;
            settle();
            chk("bp_hold_valid", 128'(rfex_tvalid), 128'(1'b1));
            chk("bp_hold_data", 128'(rfex_tdata), 128'(exp_out(32'h55, 32'h55, ins_h)));
            chk("bp_hold_ready", 128'(idrf_tready_c), 128'(1'b0));
        end
        rfex_tready = 1'b1;
        settle();
        chk("bp_resume_ready", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("bp_data_i", 128'(rfex_tdata), 128'(exp_out(32'hDEADBEEF, 32'h0, ins_i)));
        idrf_tvalid = 1'b0;
        tick();
        chk("bp_no_dup", 128'(rfex_tvalid), 128'(1'b0));

        // Writeback to x0 is ignored
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        wb_tvalid = 1'b0;
        issue(ins_j);
        tick();
        chk("x0_zero", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_j)));
        idrf_tvalid = 1'b0;
        tick();

        // Flush with busy[7] set and output valid
        issue(ins_k);
        tick();
        rfex_tready = 1'b0;
        chk("flush_pre_valid", 128'(rfex_tvalid), 128'(1'b1));
        issue(ins_l);
        invalidate = 1'b1;
        settle();
        chk("flush_ready_low", 128'(idrf_tready_c), 128'(1'b0));
        tick();
        invalidate = 1'b0;
        chk("flush_tvalid", 128'(rfex_tvalid), 128'(1'b0));
        settle();
        chk("flush_busy_clear", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("flush_data_l", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_l)));
        rfex_tready = 1'b1;
        idrf_tvalid = 1'b0;
        wb(5'd7, 32'h0000_0012);
        tick();
        wb_tvalid = 1'b0;
        issue(ins_m);
        settle();
        chk("flush_ready_m", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("flush_wb_x7", 128'(rfex_tdata), 128'(exp_out(32'h12, 32'h0, ins_m)));
        idrf_tvalid = 1'b0;
        tick();

        // Reset mid-stream with the output valid and x5 written
        issue(ins_n);
        tick();
        idrf_tvalid = 1'b0;
        rfex_tready = 1'b0;
        wb(5'd5, 32'h0000_0077);
        tick();
        wb_tvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_tvalid", 128'(rfex_tvalid), 128'(1'b0));
        chk("midrst_tdata", 128'(rfex_tdata), 128'h0);
        #2 rst = 1'b1;
        rfex_tready = 1'b1;
        issue(ins_p);
        settle();
        chk("midrst_busy_clear", 128'(idrf_tready_c), 128'(1'b1));
        tick();
        chk("midrst_x5_zero", 128'(rfex_tdata), 128'(exp_out(32'h0, 32'h0, ins_p)));
        idrf_tvalid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
